// File: rtl/iot_extreme_filter.sv
// rtl/iot_extreme_filter.sv - group max/min reducer with running global peak tracking
module iot_extreme_filter #(
    parameter int DATA_W  = 128,
    parameter int GROUP_N = 16,
    parameter int CNT_W   = $clog2(GROUP_N + 1)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [1:0]        i_mode,
    input  logic              i_clear,
    input  logic              i_in_valid,
    input  logic [DATA_W-1:0] i_in_data,
    output logic              o_in_ready,
    output logic              o_out_valid,
    input  logic              i_out_ready,
    output logic [DATA_W-1:0] o_out_data,
    output logic              o_out_peak,
    output logic              o_busy,
    output logic [7:0]        o_grp_cnt
);

    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_EMIT} state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(GROUP_N - 1);
    localparam logic             SINGLE   = (GROUP_N == 1);

    state_t              r_state;
    logic [DATA_W-1:0]   r_acc;
    logic [CNT_W-1:0]    r_cnt;
    logic [DATA_W-1:0]   r_global;
    logic                r_have_global;
    logic [1:0]          r_lmode;
    logic [DATA_W-1:0]   r_out_data;
    logic                r_out_peak;
    logic                r_out_valid;
    logic [7:0]          r_grp_cnt;

    logic                w_accept;
    logic [DATA_W-1:0]   w_new_acc;
    logic                w_last;
    logic                w_to_emit;
    logic [DATA_W-1:0]   w_fin_acc;
    logic [1:0]          w_fin_mode;
    logic                w_fin_peak;
    logic                w_emit_done;
    logic                w_new_global;

    // Strict "a is more extreme than b" in the direction selected by min_dir
    function automatic logic f_beats(input logic [DATA_W-1:0] a,
                                     input logic [DATA_W-1:0] b,
                                     input logic              min_dir);
        return min_dir ? (a < b) : (a > b);
    endfunction

    assign o_in_ready   = (r_state != S_EMIT);
    assign o_busy       = (r_state != S_IDLE);
    assign o_out_valid  = r_out_valid;
    assign o_out_data   = r_out_data;
    assign o_out_peak   = r_out_peak;
    assign o_grp_cnt    = r_grp_cnt;

    assign w_accept     = i_in_valid & o_in_ready;
    assign w_new_acc    = f_beats(i_in_data, r_acc, r_lmode[0]) ? i_in_data : r_acc;
    assign w_last       = (r_cnt == LAST_CNT);
    assign w_emit_done  = ~r_out_valid | i_out_ready;
    assign w_new_global = ~r_have_global | f_beats(r_acc, r_global, r_lmode[0]);

    // Final group result as seen on the edge that closes the group (IDLE only when GROUP_N==1)
    always_comb begin
        w_fin_acc  = w_new_acc;
        w_fin_mode = r_lmode;
        w_to_emit  = 1'b0;
        if (r_state == S_IDLE) begin
            w_fin_acc  = i_in_data;
            w_fin_mode = i_mode;
            w_to_emit  = w_accept & SINGLE;
        end else if (r_state == S_ACCUM) begin
            w_to_emit  = w_accept & w_last;
        end
        w_fin_peak = r_have_global & f_beats(w_fin_acc, r_global, w_fin_mode[0]);
    end

    // Group accumulation, emit handshake and global-extreme bookkeeping
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state       <= S_IDLE;
            r_acc         <= '0;
            r_cnt         <= '0;
            r_global      <= '0;
            r_have_global <= 1'b0;
            r_lmode       <= 2'b00;
            r_out_data    <= '0;
            r_out_peak    <= 1'b0;
            r_out_valid   <= 1'b0;
            r_grp_cnt     <= 8'd0;
        end else if (i_clear) begin
            r_state       <= S_IDLE;
            r_acc         <= '0;
            r_cnt         <= '0;
            r_global      <= '0;
            r_have_global <= 1'b0;
            r_lmode       <= 2'b00;
            r_out_data    <= '0;
            r_out_peak    <= 1'b0;
            r_out_valid   <= 1'b0;
            r_grp_cnt     <= 8'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_acc   <= i_in_data;
                        r_cnt   <= CNT_W'(1);
                        r_lmode <= i_mode;
                        r_state <= SINGLE ? S_EMIT : S_ACCUM;
                    end
                end
                S_ACCUM: begin
                    if (w_accept) begin
                        r_acc <= w_new_acc;
                        r_cnt <= r_cnt + CNT_W'(1);
                        if (w_last) begin
                            r_state <= S_EMIT;
                        end
                    end
                end
                S_EMIT: begin
                    if (w_emit_done) begin
                        r_state     <= S_IDLE;
                        r_out_data  <= '0;
                        r_out_peak  <= 1'b0;
                        r_out_valid <= 1'b0;
                        if (r_grp_cnt != 8'hFF) begin
                            r_grp_cnt <= r_grp_cnt + 8'd1;
                        end
                        if (w_new_global) begin
                            r_global      <= r_acc;
                            r_have_global <= 1'b1;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
            if (w_to_emit) begin
                r_out_data  <= w_fin_acc;
                r_out_peak  <= w_fin_peak;
                r_out_valid <= w_fin_mode[1] ? w_fin_peak : 1'b1;
            end
        end
    end

endmodule

// File: doc/iot_extreme_filter.md
Name: iot_extreme_filter

Overview:
- Parametrised successor to the fixed 16-sample, 128-bit minimum filter in the IoT data-filtering path.
- Accepts a valid/ready sample stream and reduces each group of GROUP_N unsigned samples to its maximum or minimum.
- Tracks a running global extreme across groups and flags or emits a group only when it sets a new global extreme (peak modes).
- Sits after the data-input sequencer and feeds the result/output-enable mux.

Parameters:
DATA_W, 128, sample width in bits; all comparisons unsigned.
GROUP_N, 16, samples per group; legal range 1..255.
CNT_W, $clog2(GROUP_N+1), sample-counter width (derived; do not override).

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-low reset (0 = reset)
mode  input  2  00 group max; 01 group min; 10 peak max; 11 peak min
clear  input  1  synchronous clear of group and global state
in_valid  input  1  sample valid
in_data  input  DATA_W  sample
in_ready  output  1  block accepts a sample this cycle
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
out_data  output  DATA_W  group extreme
out_peak  output  1  group extreme strictly beats the previous global extreme
busy  output  1  state != IDLE
grp_cnt  output  8  completed groups since reset/clear, saturating at 255

Behaviour:
- Reset (rst=0, async):
  - state=IDLE; acc, cnt, global, have_global, lmode cleared.
  - All outputs 0, except in_ready, which is combinational and reads 1 in IDLE.
- States: IDLE, ACCUM, EMIT.
- A sample is accepted when in_valid & in_ready.
- in_ready=1 in IDLE and ACCUM, 0 in EMIT.
- IDLE, on accept:
  - acc<=in_data, cnt<=1, lmode<=mode.
  - Go to EMIT if GROUP_N==1, else to ACCUM.
- ACCUM, on accept:
  - Max modes (lmode[0]=0): acc<=in_data if in_data>acc.
  - Min modes: acc<=in_data if in_data<acc.
  - Ties keep acc.
  - cnt<=cnt+1. When the accepted sample is number GROUP_N, go to EMIT using the updated acc.
- No accept in ACCUM: hold all state. Gaps in in_valid are allowed.
- mode is sampled only at the first sample of a group. Changes mid-group have no effect until the next group.
- EMIT entry (registered):
  - out_data<=final acc.
  - out_peak<=have_global & (acc beats global strictly in lmode's direction).
- EMIT, out_valid:
  - Modes 00/01: out_valid=1.
  - Modes 10/11: out_valid=out_peak.
- EMIT exit:
  - If out_valid=1: on out_ready, go to IDLE. Hold out_valid/out_data stable until then.
  - If out_valid=0 (peak group dropped): go to IDLE after exactly one cycle.
- Leaving EMIT:
  - If !have_global, or the group strictly beats global: global<=acc and have_global<=1.
  - grp_cnt increments (saturating).
  - out_valid, out_peak and out_data drop to 0 in IDLE.
- First group after reset/clear:
  - Sets the baseline; out_peak=0.
  - Emitted in modes 00/01, dropped in modes 10/11.
- Global comparison direction follows the current group's lmode. The global is not reset on mode change; software asserts clear when switching direction.
- clear=1 (sync, priority over every transition):
  - Next state IDLE; acc, cnt, global, have_global, grp_cnt cleared; out_* cleared.
  - Any partial group or pending output is discarded.
  - in_ready stays 1 during clear, but a sample accepted in a clear cycle is discarded.
- Latency: last sample accepted at edge t → out_valid=1 from edge t+1 (one-cycle latency).
- Throughput: one group per GROUP_N+1 cycles with out_ready tied high.
- Reset asserted mid-group or mid-EMIT: immediate return to reset values. No partial result is ever emitted.

Test Plan:
- GROUP_N=4, DATA_W=8, mode 01, samples 9,3,7,5 back-to-back → one cycle after the 4th accept: out_valid=1, out_data=3, out_peak=0, grp_cnt becomes 1 on exit.
- Mode 00, groups {1,8,2,4} then {9,0,0,0} then {9,1,1,1} →
  - out_data 8 (peak 0), then 9 (peak 1), then 9 (peak 0: tie is not a new extreme).
- Mode 11, groups {5,6,7,8} then {6,6,6,6} then {2,9,9,9} →
  - Group 1: no out_valid (baseline).
  - Group 2: dropped after one EMIT cycle, busy=1 during ACCUM/EMIT.
  - Group 3: out_valid=1, out_data=2, out_peak=1.
- Backpressure: out_ready=0 for 5 cycles after EMIT → out_valid and out_data held, in_ready=0; in_valid pulses during this time are not accepted; release → IDLE next cycle.
- clear asserted after 2 of 4 samples → block returns to IDLE, grp_cnt=0. Next full group {4,4,1,4} in mode 01 emits 1 with out_peak=0 (first group again).
- rst pulsed low mid-ACCUM and again during EMIT with out_ready=0 → all outputs 0 immediately (async), no stale out_valid after release.
